card_dealer: RTL and testbench

//  Upstream stage of game_control. Deals up to four cards (values 1..9) on debounced HIT presses.

---
 rtl/blackjack_pkg.sv | 24 ++
 rtl/lfsr_card_gen.sv | 23 ++
 rtl/card_dealer.sv | 139 +++++++++++++
 tb/tb_card_dealer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared blackjack encodings and constants for card_dealer and game_control.
package blackjack_pkg;

  typedef enum logic [1:0] {GsIdle, GsS100, GsS200, GsS300} game_state_e;

  typedef enum logic [2:0] {
    DlrIdle,
    DlrOne,
    DlrTwo,
    DlrThree,
    DlrFour,
    DlrOver
  } dealer_state_e;

  localparam int unsigned CARD_MIN   = 1;
  localparam int unsigned CARD_MAX   = 9;
  localparam int unsigned TARGET_SUM = 17;

  // Maps any LFSR state onto CARD_MIN..CARD_MAX.
  function automatic logic [3:0] lfsr_to_card(input logic [7:0] v);
    return 4'(v % 8'(CARD_MAX - CARD_MIN + 1)) + 4'(CARD_MIN);
  endfunction

endpackage

// File: rtl/lfsr_card_gen.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with card value mapping.
module lfsr_card_gen
  import blackjack_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] card_val
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign card_val = lfsr_to_card(lfsr_q);

endmodule

// File: rtl/card_dealer.sv
// Deals up to four cards on debounced hit presses; undealt cards read as zero.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GUARD_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit_btn,
  input  logic       new_game,
  input  logic       win_pulse,
  input  logic       lose_pulse,
  output logic [3:0] first_card,
  output logic [3:0] second_card,
  output logic [3:0] third_card,
  output logic [3:0] fourth_card,
  output logic [1:0] cstate,
  output logic [2:0] card_count,
  output logic       deal_valid,
  output logic       game_over
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned GdW = $clog2(GUARD_CYCLES + 1);

  logic           sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [DbW-1:0] db_cnt_q;
  logic           hit_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      sync1_q     <= hit_btn;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      if (sync2_q == filt_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q   <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign hit_req = filt_q & ~filt_prev_q;

  logic [3:0] card_val;

  lfsr_card_gen #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .card_val(card_val)
  );

  dealer_state_e  state_q, state_d;
  logic [3:0]     cards_q [4];
  logic [2:0]     card_count_q;
  logic           deal_valid_q;
  logic [GdW-1:0] guard_q;
  logic           verdict, hit_ok, deal;

  assign verdict = win_pulse | lose_pulse;
  assign hit_ok  = hit_req && (guard_q == '0) && !new_game;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DlrIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = DlrIdle;
    end else begin
      case (state_q)
        DlrIdle:  if (deal) state_d = DlrOne;
        DlrOne:   if (verdict) state_d = DlrOver; else if (deal) state_d = DlrTwo;
        DlrTwo:   if (verdict) state_d = DlrOver; else if (deal) state_d = DlrThree;
        DlrThree: if (verdict) state_d = DlrOver; else if (deal) state_d = DlrFour;
        DlrFour:  state_d = DlrOver;
        DlrOver:  state_d = DlrOver;
        default:  state_d = DlrIdle;
      endcase
    end
  end

  // A verdict arriving with a hit wins; win/lose carry no meaning before a card is out.
  always_comb begin
    deal = 1'b0;
    case (state_q)
      DlrIdle:                  deal = hit_ok;
      DlrOne, DlrTwo, DlrThree: deal = hit_ok & ~verdict;
      default:                  deal = 1'b0;
    endcase
    game_over = (state_q == DlrOver);
    cstate    = (card_count_q >= 3'd3) ? 2'd3 : card_count_q[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) cards_q[i] <= 4'd0;
      card_count_q <= 3'd0;
      deal_valid_q <= 1'b0;
      guard_q      <= '0;
    end else begin
      deal_valid_q <= deal;
      if (new_game) begin
        for (int i = 0; i < 4; i++) cards_q[i] <= 4'd0;
        card_count_q <= 3'd0;
        guard_q      <= '0;
      end else if (deal) begin
        cards_q[card_count_q[1:0]] <= card_val;
        card_count_q               <= card_count_q + 3'd1;
        guard_q                    <= GdW'(GUARD_CYCLES);
      end else if (guard_q != '0) begin
        guard_q <= guard_q - 1'b1;
      end
    end
  end

  assign first_card  = cards_q[0];
  assign second_card = cards_q[1];
  assign third_card  = cards_q[2];
  assign fourth_card = cards_q[3];
  assign card_count  = card_count_q;
  assign deal_valid  = deal_valid_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with an LFSR reference model and a game_control stand-in.
module tb_card_dealer;
  import blackjack_pkg::*;

  logic       clk = 1'b0;
  logic       rst, hit_btn, new_game, win_pulse, lose_pulse;
  logic [3:0] first_card, second_card, third_card, fourth_card;
  logic [1:0] cstate;
  logic [2:0] card_count;
  logic       deal_valid, game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int deals    = 0;

  card_dealer #(
    .LFSR_SEED      (8'hA5),
    .DEBOUNCE_CYCLES(16),
    .GUARD_CYCLES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hit_btn    (hit_btn),
    .new_game   (new_game),
    .win_pulse  (win_pulse),
    .lose_pulse (lose_pulse),
    .first_card (first_card),
    .second_card(second_card),
    .third_card (third_card),
    .fourth_card(fourth_card),
    .cstate     (cstate),
    .card_count (card_count),
    .deal_valid (deal_valid),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] ahead(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  function automatic logic [3:0] card_of(input logic [7:0] v);
    return 4'(v % 8'd9) + 4'd1;
  endfunction

  // pred: the card the DUT would have written at the most recent edge.
  logic [7:0] mdl_lfsr;
  logic [3:0] pred;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_lfsr <= 8'hA5;
      pred     <= 4'd0;
    end else begin
      mdl_lfsr <= step(mdl_lfsr);
      pred     <= card_of(mdl_lfsr);
    end
  end

  // game_control stand-in: registers a verdict the cycle after a card change.
  int hand_sum;
  assign hand_sum = int'(first_card) + int'(second_card) + int'(third_card) + int'(fourth_card);
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
    end else begin
      win_pulse  <= (deal_valid === 1'b1) && (hand_sum == int'(TARGET_SUM));
      lose_pulse <= (deal_valid === 1'b1) && (hand_sum > int'(TARGET_SUM));
    end
  end

  always @(negedge clk) if (deal_valid === 1'b1) deals <= deals + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] card_at(input int i);
    case (i)
      0:       return first_card;
      1:       return second_card;
      2:       return third_card;
      3:       return fourth_card;
      default: return 4'hF;
    endcase
  endfunction

  // Presses so that the deal edge (18 cycles later) picks the requested value; 0 = any.
  task automatic deal_card(input int target, input string tag);
    int n = 0;
    int idx;
    while (target != 0 && int'(card_of(ahead(mdl_lfsr, 18))) != target && n < 600) begin
      @(negedge clk);
      n++;
    end
    hit_btn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (deal_valid !== 1'b1 && n < 40);
    check({tag, "_deal"}, 32'(deal_valid), 1);
    idx = int'(card_count) - 1;
    check({tag, "_val"}, 32'(card_at(idx)), (target != 0) ? target : int'(pred));
  endtask

  task automatic release_btn();
    hit_btn = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_c1"}, 32'(first_card), 0);
    check({tag, "_c2"}, 32'(second_card), 0);
    check({tag, "_c3"}, 32'(third_card), 0);
    check({tag, "_c4"}, 32'(fourth_card), 0);
    check({tag, "_cnt"}, 32'(card_count), 0);
    check({tag, "_cst"}, 32'(cstate), 0);
    check({tag, "_over"}, 32'(game_over), 0);
  endtask

  initial begin
    int d0;
    int n;
    rst = 1'b0; hit_btn = 1'b0; new_game = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check_clear("idle50");
    check("idle50_dv", 32'(deal_valid), 0);

    // Bouncing press then a clean hold: one deal only.
    d0 = deals;
    for (int i = 0; i < 10; i++) begin
      hit_btn = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    hit_btn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (deal_valid !== 1'b1 && n < 60);
    check("bounce_deal", 32'(deal_valid), 1);
    check("bounce_range", 32'(first_card >= 4'd1 && first_card <= 4'd9), 1);
    check("bounce_val", 32'(first_card), 32'(pred));
    repeat (30) @(negedge clk);
    check("bounce_once", deals - d0, 1);
    check("bounce_cnt", 32'(card_count), 1);
    release_btn();
    pulse_new_game();
    check_clear("ng1");

    // 8 + 9 = 17: verdict lands two cycles after the second deal.
    deal_card(8, "w8");
    release_btn();
    deal_card(9, "w9");
    check("win_t0", 32'(game_over), 0);
    @(negedge clk);
    check("win_t1", 32'(game_over), 0);
    @(negedge clk);
    check("win_t2", 32'(game_over), 1);
    release_btn();
    d0 = deals;
    hit_btn = 1'b1;
    repeat (30) @(negedge clk);
    check("over_c3", 32'(third_card), 0);
    check("over_nodeal", deals - d0, 0);
    check("over_hold", 32'(second_card), 9);
    release_btn();
    pulse_new_game();
    check_clear("ng2");

    // 5 + 6 + 7 = 18: lose.
    deal_card(5, "l5");
    release_btn();
    deal_card(6, "l6");
    release_btn();
    deal_card(7, "l7");
    repeat (2) @(negedge clk);
    check("lose_over", 32'(game_over), 1);
    check("lose_c1", 32'(first_card), 5);
    check("lose_c2", 32'(second_card), 6);
    check("lose_c3", 32'(third_card), 7);
    check("lose_c4", 32'(fourth_card), 0);
    check("lose_cst", 32'(cstate), 3);
    release_btn();
    pulse_new_game();
    check_clear("ng3");

    // Four cards without a verdict, then forced OVER.
    deal_card(2, "f2");
    release_btn();
    deal_card(3, "f3");
    release_btn();
    deal_card(4, "f4");
    release_btn();
    deal_card(5, "f5");
    check("four_cnt", 32'(card_count), 4);
    check("four_cst", 32'(cstate), 3);
    check("four_notover", 32'(game_over), 0);
    @(negedge clk);
    check("four_over", 32'(game_over), 1);
    release_btn();
    pulse_new_game();
    check_clear("ng4");

    // new_game coincident with hit_req.
    d0 = deals;
    hit_btn = 1'b1;
    repeat (18) @(posedge clk);
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("ngh_dv", 32'(deal_valid), 0);
    repeat (10) @(negedge clk);
    check("ngh_nodeal", deals - d0, 0);
    check_clear("ngh");
    release_btn();

    // Asynchronous reset while holding two cards.
    deal_card(1, "r1");
    release_btn();
    deal_card(2, "r2");
    release_btn();
    check("r_cnt", 32'(card_count), 2);
    #2 rst = 1'b0;
    #1;
    check_clear("rst");
    check("rst_seed", 32'(dut.u_lfsr.lfsr_q), 32'h A5);
    @(negedge clk);
    rst = 1'b1;
    deal_card(0, "post_rst");
    check("post_rst_cnt", 32'(card_count), 1);
    release_btn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
